// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron array: FSM states, default widths, saturation.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lif_state_t;

  localparam int LIF_WIDTH    = 8;
  localparam int LIF_REFRAC_W = 4;

  // Clamp an unsigned value to the largest number representable in w bits (w <= 32).
  function automatic logic [31:0] lif_sat(input logic [32:0] val, input int unsigned w);
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    return (val > lim) ? lim[31:0] : val[31:0];
  endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// Single-neuron LIF update: leak, integrate, saturate, fire, refractory bookkeeping.
// Latency: purely combinational, result consumed by the caller on the same edge.
// Backpressure: none; the caller decides when the result is written back.
module lif_neuron_core
  import lif_pkg::*;
#(
  parameter int WIDTH         = LIF_WIDTH,
  parameter int REFRAC_CYCLES = 2,
  parameter int REFRAC_W      = LIF_REFRAC_W
) (
  input  logic [WIDTH-1:0]    i_v,
  input  logic [WIDTH-1:0]    i_cur,
  input  logic [WIDTH-1:0]    i_thr,
  input  logic [2:0]          i_shift,
  input  logic [REFRAC_W-1:0] i_rcnt,
  output logic [WIDTH-1:0]    o_v,
  output logic [REFRAC_W-1:0] o_rcnt,
  output logic                o_spike
);

  logic [WIDTH-1:0] w_leak;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_vn;

  // Candidate membrane: V minus leak plus current, one extra bit, then clamped to full scale.
  // A shift of WIDTH or more simply yields zero leak.
  always_comb begin
    w_leak = '0;
    if (i_shift != 3'd0) begin
      w_leak = i_v >> i_shift;
    end
    w_sum = {1'b0, i_v} - {1'b0, w_leak} + {1'b0, i_cur};
    w_vn  = WIDTH'(lif_sat(33'(w_sum), WIDTH));
  end

  // Refractory neurons are held at zero; otherwise fire on reaching threshold.
  always_comb begin
    o_v     = w_vn;
    o_rcnt  = '0;
    o_spike = 1'b0;
    if (i_rcnt != '0) begin
      o_v    = '0;
      o_rcnt = i_rcnt - REFRAC_W'(1);
    end else if (w_vn >= i_thr) begin
      o_v     = '0;
      o_rcnt  = REFRAC_W'(REFRAC_CYCLES);
      o_spike = 1'b1;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N LIF neurons sharing one time-multiplexed core; optional spike counters (LIF_SPIKE_COUNT_EN).
// Latency: accept at edge t -> spike_out/step_done at edge t+N+1; next accept possible at t+N+2.
// Backpressure: step_ready is high only in IDLE; step_valid is ignored while a step runs.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS     = 4,
  parameter int WIDTH         = LIF_WIDTH,
  parameter int REFRAC_CYCLES = 2,
  parameter int REFRAC_W      = LIF_REFRAC_W,
  localparam int SEL_W        = $clog2(N_NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step_valid,
  output logic                       step_ready,
  input  logic [N_NEURONS*WIDTH-1:0] cur_in,
  input  logic [WIDTH-1:0]           threshold,
  input  logic [2:0]                 leak_shift,
  output logic [N_NEURONS-1:0]       spike_out,
  output logic                       step_done,
  input  logic [SEL_W-1:0]           vmem_sel,
  output logic [WIDTH-1:0]           vmem_out
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [15:0]                spike_cnt_out
`endif
);

  lif_state_t                 r_state;
  logic [SEL_W-1:0]           r_idx;
  logic [N_NEURONS*WIDTH-1:0] r_cur;
  logic [WIDTH-1:0]           r_thr;
  logic [2:0]                 r_shift;
  logic [WIDTH-1:0]           r_v    [N_NEURONS];
  logic [REFRAC_W-1:0]        r_rcnt [N_NEURONS];
  logic [N_NEURONS-1:0]       r_acc;
  logic [N_NEURONS-1:0]       r_spike;
  logic                       r_done;
`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0]                r_cnt  [N_NEURONS];
`endif

  logic [WIDTH-1:0]    w_cur;
  logic [WIDTH-1:0]    w_v_nxt;
  logic [REFRAC_W-1:0] w_rcnt_nxt;
  logic                w_spike;
  logic                w_last;

  assign w_cur      = r_cur[r_idx*WIDTH +: WIDTH];
  assign w_last     = (r_idx == SEL_W'(N_NEURONS - 1));
  assign step_ready = (r_state == ST_IDLE);
  assign spike_out  = r_spike;
  assign step_done  = r_done;

  lif_neuron_core #(
    .WIDTH        (WIDTH),
    .REFRAC_CYCLES(REFRAC_CYCLES),
    .REFRAC_W     (REFRAC_W)
  ) u_core (
    .i_v    (r_v[r_idx]),
    .i_cur  (w_cur),
    .i_thr  (r_thr),
    .i_shift(r_shift),
    .i_rcnt (r_rcnt[r_idx]),
    .o_v    (w_v_nxt),
    .o_rcnt (w_rcnt_nxt),
    .o_spike(w_spike)
  );

  // Step sequencer: latch inputs on accept, sweep one neuron per cycle, publish spikes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cur   <= '0;
      r_thr   <= '0;
      r_shift <= '0;
      r_acc   <= '0;
      r_spike <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_v[i]    <= '0;
        r_rcnt[i] <= '0;
`ifdef LIF_SPIKE_COUNT_EN
        r_cnt[i]  <= '0;
`endif
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (step_valid) begin
            r_cur   <= cur_in;
            r_thr   <= threshold;
            r_shift <= leak_shift;
            r_idx   <= '0;
            r_acc   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_v[r_idx]    <= w_v_nxt;
          r_rcnt[r_idx] <= w_rcnt_nxt;
          r_acc[r_idx]  <= w_spike;
`ifdef LIF_SPIKE_COUNT_EN
          if (w_spike && (r_cnt[r_idx] != 16'hFFFF)) begin
            r_cnt[r_idx] <= r_cnt[r_idx] + 16'd1;
          end
`endif
          if (w_last) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + SEL_W'(1);
          end
        end
        ST_DONE: begin
          r_spike <= r_acc;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Debug readout of the selected neuron; a select with no matching neuron reads zero.
  always_comb begin
    vmem_out = '0;
`ifdef LIF_SPIKE_COUNT_EN
    spike_cnt_out = '0;
`endif
    for (int i = 0; i < N_NEURONS; i++) begin
      if (vmem_sel == SEL_W'(i)) begin
        vmem_out = r_v[i];
`ifdef LIF_SPIKE_COUNT_EN
        spike_cnt_out = r_cnt[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array (N=4, WIDTH=8, REFRAC_CYCLES=2).
// Latency: expects step_done N+1 cycles after each accept.
// Backpressure: holds step_valid high to check that accepts are spaced N+2 cycles apart.
module tb_lif_neuron_array;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         step_valid;
  logic         step_ready;
  logic [31:0]  cur_in;
  logic [7:0]   threshold;
  logic [2:0]   leak_shift;
  logic [3:0]   spike_out;
  logic         step_done;
  logic [1:0]   vmem_sel;
  logic [7:0]   vmem_out;
`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0]  spike_cnt_out;
`endif

  lif_neuron_array #(
    .N_NEURONS    (N),
    .WIDTH        (W),
    .REFRAC_CYCLES(2),
    .REFRAC_W     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .cur_in    (cur_in),
    .threshold (threshold),
    .leak_shift(leak_shift),
    .spike_out (spike_out),
    .step_done (step_done),
    .vmem_sel  (vmem_sel),
    .vmem_out  (vmem_out)
`ifdef LIF_SPIKE_COUNT_EN
    ,
    .spike_cnt_out(spike_cnt_out)
`endif
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [31:0] cur;
    logic [7:0]  thr;
    logic [2:0]  sh;
    logic [3:0]  spk;
    logic [31:0] v;
  } vec_t;

  typedef struct packed {
    logic [3:0]  spk;
    logic [31:0] v;
  } exp_t;

  vec_t vecs [13];
  exp_t sb_q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one step, push its expectation, wait (bounded) for step_done, pop and compare.
  task automatic do_step(input vec_t vv, input string tag);
    int   cyc;
    exp_t e;
    @(negedge clk);
    chk({tag, " ready"}, 32'(step_ready), 32'd1);
    cur_in     = vv.cur;
    threshold  = vv.thr;
    leak_shift = vv.sh;
    step_valid = 1'b1;
    e.spk = vv.spk;
    e.v   = vv.v;
    sb_q.push_back(e);
    @(posedge clk);
    #1 step_valid = 1'b0;
    cyc = 0;
    while (!step_done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(N + 1));
    e = sb_q.pop_front();
    chk({tag, " spike_out"}, 32'(spike_out), 32'(e.spk));
    for (int i = 0; i < N; i++) begin
      vmem_sel = 2'(i);
      #1;
      chk($sformatf("%s vmem%0d", tag, i), 32'(vmem_out), 32'(e.v[i*8 +: 8]));
    end
  endtask

  initial begin
    int acc_cyc [$];
    int cyc;
    int pulses;
    vec_t vx;

    // cur packs neuron i at [i*8 +: 8]; v packs expected membranes the same way.
    vecs[0]  = '{cur: 32'h32323232, thr: 8'd100, sh: 3'd0, spk: 4'h0, v: 32'h32323232};
    vecs[1]  = '{cur: 32'h32323232, thr: 8'd100, sh: 3'd0, spk: 4'hF, v: 32'h00000000};
    vecs[2]  = '{cur: 32'hFFFFFFFF, thr: 8'd10,  sh: 3'd0, spk: 4'h0, v: 32'h00000000};
    vecs[3]  = '{cur: 32'hFFFFFFFF, thr: 8'd10,  sh: 3'd0, spk: 4'h0, v: 32'h00000000};
    vecs[4]  = '{cur: 32'hFFFFFFFF, thr: 8'd10,  sh: 3'd0, spk: 4'hF, v: 32'h00000000};
    vecs[5]  = '{cur: 32'h00000000, thr: 8'd255, sh: 3'd0, spk: 4'h0, v: 32'h00000000};
    vecs[6]  = '{cur: 32'h00000000, thr: 8'd255, sh: 3'd0, spk: 4'h0, v: 32'h00000000};
    vecs[7]  = '{cur: 32'h0A00C840, thr: 8'd255, sh: 3'd0, spk: 4'h0, v: 32'h0A00C840};
    vecs[8]  = '{cur: 32'h0000C800, thr: 8'd255, sh: 3'd2, spk: 4'h2, v: 32'h08000030};
    vecs[9]  = '{cur: 32'h00000000, thr: 8'd255, sh: 3'd0, spk: 4'h0, v: 32'h08000030};
    vecs[10] = '{cur: 32'h00050000, thr: 8'd255, sh: 3'd7, spk: 4'h0, v: 32'h08050030};
    vecs[11] = '{cur: 32'h00000000, thr: 8'd0,   sh: 3'd0, spk: 4'hF, v: 32'h00000000};
    vecs[12] = '{cur: 32'h00000000, thr: 8'd0,   sh: 3'd0, spk: 4'h0, v: 32'h00000000};

    rst        = 1'b1;
    step_valid = 1'b0;
    cur_in     = '0;
    threshold  = '0;
    leak_shift = '0;
    vmem_sel   = '0;
    repeat (2) @(negedge clk);
    chk("rst spike_out", 32'(spike_out), 32'd0);
    chk("rst step_done", 32'(step_done), 32'd0);
    chk("rst step_ready", 32'(step_ready), 32'd1);
    chk("rst vmem", 32'(vmem_out), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 13; k++) begin
      do_step(vecs[k], $sformatf("vec%0d", k));
    end

`ifdef LIF_SPIKE_COUNT_EN
    vmem_sel = 2'd0;
    #1;
    chk("spike count n0", 32'(spike_cnt_out), 32'd3);
`endif

    // Continuous step_valid: accepts every N+2 cycles, none while running.
    @(negedge clk);
    cur_in     = 32'h1E1E1E1E;
    threshold  = 8'd255;
    leak_shift = 3'd0;
    step_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (step_ready) acc_cyc.push_back(c);
      @(negedge clk);
    end
    step_valid = 1'b0;
    chk("hs accept count", 32'(acc_cyc.size()), 32'd4);
    if (acc_cyc.size() == 4) begin
      chk("hs first accept", 32'(acc_cyc[0]), 32'd0);
      for (int k = 1; k < 4; k++) begin
        chk($sformatf("hs gap%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(N + 2));
      end
    end
    cyc = 0;
    while (!step_done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("hs drain done", 32'(step_done), 32'd1);
    vmem_sel = 2'd0;
    #1;
    chk("hs vmem n0", 32'(vmem_out), 32'd90);

    // Fire everything so the mid-step reset has visible state to clear.
    vx = '{cur: 32'h00000000, thr: 8'd50, sh: 3'd0, spk: 4'hF, v: 32'h00000000};
    do_step(vx, "prefire");

    // Reset asserted partway through a step.
    @(negedge clk);
    cur_in     = 32'h32323232;
    threshold  = 8'd255;
    step_valid = 1'b1;
    @(posedge clk);
    #1 step_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid ready low", 32'(step_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid rst spike_out", 32'(spike_out), 32'd0);
    chk("mid rst step_done", 32'(step_done), 32'd0);
    chk("mid rst step_ready", 32'(step_ready), 32'd1);
    for (int i = 0; i < N; i++) begin
      vmem_sel = 2'(i);
      #1;
      chk($sformatf("mid rst vmem%0d", i), 32'(vmem_out), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (step_done) pulses++;
    end
    chk("mid no step_done", 32'(pulses), 32'd0);
    chk("mid idle ready", 32'(step_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
